// File: rtl/wb_queue_if.sv
// Producer/drain/forwarding bundle for the write-back queue.
// slave = the queue itself, master = the producers, register file and decode side.
interface wb_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          stall;
  logic          writereg;
  logic [AW-1:0] rd;
  logic [DW-1:0] writedata;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          fwd1_hit;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_hit;
  logic [DW-1:0] fwd2_data;
  logic [CW-1:0] count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, stall, rs1, rs2,
    output alu_ready, mem_ready, writereg, rd, writedata,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, stall, rs1, rs2,
    input  alu_ready, mem_ready, writereg, rd, writedata,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue merging ALU and load results onto one register-file
// write port, with youngest-entry forwarding lookups for decode.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic       clock,
  input  logic       reset,
  wb_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    mem_idx;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    free;
  logic             alu_push;
  logic             mem_push;
  logic             pop;
  logic [DW:0]      fwd1;
  logic [DW:0]      fwd2;

  // Space is judged on registered count only: a drain this cycle frees nothing.
  assign free          = CW'(DEPTH) - count_q;
  assign bus.alu_ready = (free >= CW'(1));
  assign bus.mem_ready = bus.alu_valid ? (free >= CW'(2)) : (free >= CW'(1));

  // Writes to x0 finish the handshake but never occupy an entry.
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
  assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);
  assign pop      = (count_q != '0) && !bus.stall;

  assign bus.writereg  = pop;
  assign bus.rd        = (count_q != '0) ? rd_q[head_q]   : '0;
  assign bus.writedata = (count_q != '0) ? data_q[head_q] : '0;
  assign bus.count     = count_q;

  always_comb begin
    head_d  = head_q + PW'(pop);
    mem_idx = tail_q + PW'(alu_push);
    tail_d  = tail_q + PW'(alu_push) + PW'(mem_push);
    count_d = count_q + CW'(alu_push) + CW'(mem_push) - CW'(pop);
  end

  // Walk from oldest to youngest so the last match wins; returns {hit, data}.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] rs);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((rs != '0) && valid_q[idx] && (rd_q[idx] == rs)) begin
        res = {1'b1, data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    fwd1 = lookup(bus.rs1);
    fwd2 = lookup(bus.rs2);
  end

  assign bus.fwd1_hit  = fwd1[DW];
  assign bus.fwd1_data = fwd1[DW-1:0];
  assign bus.fwd2_hit  = fwd2[DW];
  assign bus.fwd2_data = fwd2[DW-1:0];

  // Control state; reset drops everything including offers in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)      valid_q[head_q]  <= 1'b0;
      if (alu_push) valid_q[tail_q]  <= 1'b1;
      if (mem_push) valid_q[mem_idx] <= 1'b1;
    end
  end

  // Payload storage needs no reset; valid bits and count gate every read.
  always_ff @(posedge clock) begin
    if (alu_push) begin
      rd_q[tail_q]   <= bus.alu_rd;
      data_q[tail_q] <= bus.alu_data;
    end
    if (mem_push) begin
      rd_q[mem_idx]   <= bus.mem_rd;
      data_q[mem_idx] <= bus.mem_data;
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: per-cycle vector table plus reset and x0 sequences.
module tb_wb_queue;
  logic clock;
  logic reset;

  wb_queue_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        st;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ardy;
    logic        mrdy;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(
    input int unsigned av, ard, adat, mv, mrd, mdat, st, rs1, rs2,
    input int unsigned ardy, mrdy, wr, rd, wd, h1, d1, h2, d2, cnt
  );
    vec_t v;
    v.av = 1'(av);   v.ard = 5'(ard); v.adat = adat;
    v.mv = 1'(mv);   v.mrd = 5'(mrd); v.mdat = mdat;
    v.st = 1'(st);   v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.ardy = 1'(ardy); v.mrdy = 1'(mrdy); v.wr = 1'(wr);
    v.rd = 5'(rd);   v.wd = wd;
    v.h1 = 1'(h1);   v.d1 = d1; v.h2 = 1'(h2); v.d2 = d2;
    v.cnt = 3'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic st, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = mdat;
    bus.stall = st; bus.rs1 = rs1; bus.rs2 = rs2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // av ard adat mv mrd mdat st rs1 rs2 | ardy mrdy wr rd wd h1 d1 h2 d2 cnt
    vecs[0]  = mk(0,0,0,          0,0,0,      0, 0,0,  1,1,0,0,0,          0,0,0,0,0);
    vecs[1]  = mk(1,5,32'hDEADBEEF,0,0,0,     0, 5,0,  1,1,0,0,0,          0,0,0,0,0);
    vecs[2]  = mk(0,0,0,          0,0,0,      0, 5,0,  1,1,1,5,32'hDEADBEEF,1,32'hDEADBEEF,0,0,1);
    vecs[3]  = mk(0,0,0,          0,0,0,      0, 5,0,  1,1,0,0,0,          0,0,0,0,0);
    vecs[4]  = mk(1,3,32'h11,     1,4,32'h22, 1, 3,4,  1,1,0,0,0,          0,0,0,0,0);
    vecs[5]  = mk(0,0,0,          0,0,0,      1, 3,4,  1,1,0,3,32'h11,     1,32'h11,1,32'h22,2);
    vecs[6]  = mk(0,0,0,          0,0,0,      1, 3,4,  1,1,0,3,32'h11,     1,32'h11,1,32'h22,2);
    vecs[7]  = mk(0,0,0,          0,0,0,      0, 3,4,  1,1,1,3,32'h11,     1,32'h11,1,32'h22,2);
    vecs[8]  = mk(0,0,0,          0,0,0,      0, 3,4,  1,1,1,4,32'h22,     0,0,1,32'h22,1);
    vecs[9]  = mk(1,1,32'h101,    1,2,32'h102,1, 1,0,  1,1,0,0,0,          0,0,0,0,0);
    vecs[10] = mk(1,3,32'h103,    0,0,0,      1, 1,2,  1,1,0,1,32'h101,    1,32'h101,1,32'h102,2);
    vecs[11] = mk(1,4,32'h104,    1,9,32'h109,1, 3,9,  1,0,0,1,32'h101,    1,32'h103,0,0,3);
    vecs[12] = mk(1,10,32'h10A,   1,11,32'h10B,1,4,10, 0,0,0,1,32'h101,    1,32'h104,0,0,4);
    vecs[13] = mk(1,12,32'h10C,   0,0,0,      0, 9,12, 0,0,1,1,32'h101,    0,0,0,0,4);
    vecs[14] = mk(0,0,0,          0,0,0,      0, 1,2,  1,1,1,2,32'h102,    0,0,1,32'h102,3);
    vecs[15] = mk(0,0,0,          0,0,0,      0, 0,0,  1,1,1,3,32'h103,    0,0,0,0,2);
    vecs[16] = mk(1,7,32'hA,      0,0,0,      0, 7,0,  1,1,1,4,32'h104,    0,0,0,0,1);
    vecs[17] = mk(1,7,32'hB,      0,0,0,      1, 7,0,  1,1,0,7,32'hA,      1,32'hA,0,0,1);
    vecs[18] = mk(0,0,0,          0,0,0,      0, 7,0,  1,1,1,7,32'hA,      1,32'hB,0,0,2);
    vecs[19] = mk(0,0,0,          0,0,0,      0, 7,0,  1,1,1,7,32'hB,      1,32'hB,0,0,1);
    vecs[20] = mk(0,0,0,          0,0,0,      0, 7,0,  1,1,0,0,0,          0,0,0,0,0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat,
            vecs[i].st, vecs[i].rs1, vecs[i].rs2);
      #1;
      chk("alu_ready", i, 32'(bus.alu_ready), 32'(vecs[i].ardy));
      chk("mem_ready", i, 32'(bus.mem_ready), 32'(vecs[i].mrdy));
      chk("writereg",  i, 32'(bus.writereg),  32'(vecs[i].wr));
      chk("rd",        i, 32'(bus.rd),        32'(vecs[i].rd));
      chk("writedata", i, bus.writedata,      vecs[i].wd);
      chk("fwd1_hit",  i, 32'(bus.fwd1_hit),  32'(vecs[i].h1));
      chk("fwd1_data", i, bus.fwd1_data,      vecs[i].d1);
      chk("fwd2_hit",  i, 32'(bus.fwd2_hit),  32'(vecs[i].h2));
      chk("fwd2_data", i, bus.fwd2_data,      vecs[i].d2);
      chk("count",     i, 32'(bus.count),     32'(vecs[i].cnt));
      tick();
    end

    // x0 offer: handshake completes, nothing is queued.
    drive(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_alu_ready", 100, 32'(bus.alu_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_count",    101, 32'(bus.count),    32'd0);
    chk("x0_writereg", 101, 32'(bus.writereg), 32'd0);
    chk("x0_fwd1_hit", 101, 32'(bus.fwd1_hit), 32'd0);

    // Reset with three queued entries and a live offer: all discarded.
    drive(1, 1, 32'h1, 1, 2, 32'h2, 1, 0, 0);
    tick();
    drive(1, 3, 32'h3, 0, 0, 0, 1, 1, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 3);
    #1;
    chk("pre_rst_count", 200, 32'(bus.count),    32'd3);
    chk("pre_rst_hit1",  200, 32'(bus.fwd1_hit), 32'd1);
    reset = 1'b1;
    drive(1, 6, 32'h6, 0, 0, 0, 0, 1, 3);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
    #1;
    chk("rst_count",     201, 32'(bus.count),     32'd0);
    chk("rst_writereg",  201, 32'(bus.writereg),  32'd0);
    chk("rst_fwd1_hit",  201, 32'(bus.fwd1_hit),  32'd0);
    chk("rst_fwd2_hit",  201, 32'(bus.fwd2_hit),  32'd0);
    chk("rst_alu_ready", 201, 32'(bus.alu_ready), 32'd1);
    chk("rst_mem_ready", 201, 32'(bus.mem_ready), 32'd1);
    chk("rst_rd",        201, 32'(bus.rd),        32'd0);
    chk("rst_writedata", 201, bus.writedata,      32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_writereg", 202 + k, 32'(bus.writereg), 32'd0);
      chk("post_rst_count",    202 + k, 32'(bus.count),    32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
